// File: rtl/gray_bcd_adder_top.sv
// Gray-code digit-entry adder.
// Switch code is synchronized, debounced, Gray-decoded and accepted as a
// decimal digit. Three digits build operand A, three more build operand B,
// then the 4-digit BCD sum is shown on active-low 7-segment displays.
//
// state    | meaning
// ---------+-----------------------------------------------
// ENTER_A  | shifting accepted digits into operand A
// ENTER_B  | shifting accepted digits into operand B
// SHOW_SUM | displaying A+B; next digit restarts operand A
module gray_bcd_adder_top #(
    parameter int STABLE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ag,
    input  logic       bg,
    input  logic       cg,
    input  logic       dg,
    output logic [6:0] seg_unidades,
    output logic [6:0] seg_decenas,
    output logic [6:0] seg_centenas,
    output logic [6:0] seg_milesimas
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        SHOW_SUM
    } state_t;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    sync2_q;
    logic [CW-1:0] stab_cnt;
    logic          code_changed;
    logic          stable_hit;
    logic [3:0]    dec;
    logic          accept;
    logic          have_last;
    logic [3:0]    last_code;

    state_t        state;
    logic [11:0]   op_a;
    logic [11:0]   op_b;
    logic [11:0]   b_shift;
    logic [15:0]   sum_s;
    logic [1:0]    digit_cnt;

    // Three-digit BCD add with ripple decimal carry; carry-out lands in thousands.
    function automatic logic [15:0] bcd_add3(input logic [11:0] x, input logic [11:0] y);
        logic [4:0]  t;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            t = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0000, c};
            if (t > 5'd9) begin
                r[4*i +: 4] = 4'(t - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = t[3:0];
                c = 1'b0;
            end
        end
        r[15:12] = {3'b000, c};
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Synchronizer plus stability timer: reloads on any code change and
    // counts down to a terminal count of zero, where it parks.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 4'h0;
            sync2    <= 4'h0;
            sync2_q  <= 4'h0;
            stab_cnt <= STABLE_LOAD;
        end else begin
            sync1   <= {ag, bg, cg, dg};
            sync2   <= sync1;
            sync2_q <= sync2;
            if (code_changed) begin
                stab_cnt <= STABLE_LOAD;
            end else if (stab_cnt != '0) begin
                stab_cnt <= stab_cnt - CW'(1);
            end
        end
    end

    // Stability strobe, Gray decode and digit-accept qualification.
    always_comb begin
        code_changed = (sync2 != sync2_q);
        stable_hit   = !code_changed && (stab_cnt == CW'(1));
        dec          = {sync2[3],
                        sync2[3] ^ sync2[2],
                        sync2[3] ^ sync2[2] ^ sync2[1],
                        sync2[3] ^ sync2[2] ^ sync2[1] ^ sync2[0]};
        accept       = stable_hit && (dec <= 4'd9) && (!have_last || (dec != last_code));
        b_shift      = {op_b[7:0], dec};
    end

    // Remember the last accepted digit so a held code is taken only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_last <= 1'b0;
            last_code <= 4'h0;
        end else if (accept) begin
            have_last <= 1'b1;
            last_code <= dec;
        end
    end

    // Operand entry FSM; the sum is captured on the last digit of B.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTER_A;
            op_a      <= 12'h000;
            op_b      <= 12'h000;
            sum_s     <= 16'h0000;
            digit_cnt <= 2'd0;
        end else if (accept) begin
            case (state)
                ENTER_A: begin
                    op_a <= {op_a[7:0], dec};
                    if (digit_cnt == 2'd2) begin
                        state     <= ENTER_B;
                        digit_cnt <= 2'd0;
                        op_b      <= 12'h000;
                    end else begin
                        digit_cnt <= digit_cnt + 2'd1;
                    end
                end
                ENTER_B: begin
                    op_b <= b_shift;
                    if (digit_cnt == 2'd2) begin
                        sum_s     <= bcd_add3(op_a, b_shift);
                        state     <= SHOW_SUM;
                        digit_cnt <= 2'd0;
                    end else begin
                        digit_cnt <= digit_cnt + 2'd1;
                    end
                end
                SHOW_SUM: begin
                    op_a      <= {8'h00, dec};
                    digit_cnt <= 2'd1;
                    state     <= ENTER_A;
                end
                default: begin
                    state     <= ENTER_A;
                    digit_cnt <= 2'd0;
                end
            endcase
        end
    end

    // Registered segment drivers selected by what the FSM is presenting.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_unidades  <= SEG_ZERO;
            seg_decenas   <= SEG_ZERO;
            seg_centenas  <= SEG_ZERO;
            seg_milesimas <= SEG_BLANK;
        end else begin
            case (state)
                ENTER_A: begin
                    seg_unidades  <= seg7(op_a[3:0]);
                    seg_decenas   <= seg7(op_a[7:4]);
                    seg_centenas  <= seg7(op_a[11:8]);
                    seg_milesimas <= SEG_BLANK;
                end
                ENTER_B: begin
                    seg_unidades  <= seg7(op_b[3:0]);
                    seg_decenas   <= seg7(op_b[7:4]);
                    seg_centenas  <= seg7(op_b[11:8]);
                    seg_milesimas <= SEG_BLANK;
                end
                SHOW_SUM: begin
                    seg_unidades  <= seg7(sum_s[3:0]);
                    seg_decenas   <= seg7(sum_s[7:4]);
                    seg_centenas  <= seg7(sum_s[11:8]);
                    seg_milesimas <= seg7(sum_s[15:12]);
                end
                default: begin
                    seg_unidades  <= SEG_BLANK;
                    seg_decenas   <= SEG_BLANK;
                    seg_centenas  <= SEG_BLANK;
                    seg_milesimas <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_bcd_adder_top.sv
// Bench for the Gray-code digit-entry adder: directed switch codes, an
// integer-arithmetic model of operand entry and summing, and literal
// display expectations at key points.
module tb_gray_bcd_adder_top;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ag = 1'b0, bg = 1'b0, cg = 1'b0, dg = 1'b0;
    logic [6:0] seg_unidades, seg_decenas, seg_centenas, seg_milesimas;

    int passed = 0;
    int total  = 0;

    logic        chk_en = 1'b0;
    logic [27:0] exp_disp;

    // model state
    int m_phase, m_cnt, m_a, m_b, m_s, m_last;
    bit m_have;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S3 = 7'b0110000,
                           S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010,
                           S7 = 7'b1111000, S8 = 7'b0000000, SB = 7'b1111111;

    gray_bcd_adder_top #(.STABLE_CYCLES(STABLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .ag           (ag),
        .bg           (bg),
        .cg           (cg),
        .dg           (dg),
        .seg_unidades (seg_unidades),
        .seg_decenas  (seg_decenas),
        .seg_centenas (seg_centenas),
        .seg_milesimas(seg_milesimas)
    );

    always #5 clk = ~clk;

    wire [27:0] dut_disp = {seg_milesimas, seg_centenas, seg_decenas, seg_unidades};

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int gray_value(input logic [3:0] g);
        logic [3:0] gv;
        for (int n = 0; n < 16; n++) begin
            gv = 4'(n ^ (n >> 1));
            if (gv == g) return n;
        end
        return -1;
    endfunction

    function automatic logic [27:0] show3(input int v);
        return {SB, seg_of(v / 100), seg_of((v / 10) % 10), seg_of(v % 10)};
    endfunction

    function automatic logic [27:0] model_disp();
        if (m_phase == 0) return show3(m_a);
        if (m_phase == 1) return show3(m_b);
        return {seg_of(m_s / 1000), seg_of((m_s / 100) % 10), seg_of((m_s / 10) % 10), seg_of(m_s % 10)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_a = 0; m_b = 0; m_s = 0; m_last = 0; m_have = 0;
        exp_disp = model_disp();
    endtask

    function automatic bit model_apply(input logic [3:0] g, input int n);
        int d;
        if (n <= STABLE) return 0;
        d = gray_value(g);
        if (d > 9 || (m_have && d == m_last)) return 0;
        m_have = 1;
        m_last = d;
        case (m_phase)
            0: begin
                m_a = (m_a * 10 + d) % 1000;
                m_cnt++;
                if (m_cnt == 3) begin m_phase = 1; m_cnt = 0; m_b = 0; end
            end
            1: begin
                m_b = (m_b * 10 + d) % 1000;
                m_cnt++;
                if (m_cnt == 3) begin m_s = m_a + m_b; m_phase = 2; m_cnt = 0; end
            end
            default: begin
                m_a = d; m_cnt = 1; m_phase = 0;
            end
        endcase
        exp_disp = model_disp();
        return 1;
    endfunction

    // Continuous check of the display against the model whenever it is settled.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (dut_disp === exp_disp) passed++;
            else $display("FAIL disp_track t=%0t got=%h exp=%h", $time, dut_disp, exp_disp);
        end
    end

    task automatic hold(input logic [3:0] g, input int n);
        bit acc;
        chk_en = 1'b0;
        {ag, bg, cg, dg} = g;
        acc = model_apply(g, n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            chk_en = !acc || (k >= 9);
        end
        #1;
    endtask

    task automatic check_lit(input string name, input logic [27:0] lit);
        total++;
        if (dut_disp === lit) passed++;
        else $display("FAIL %s dut got=%h exp=%h", name, dut_disp, lit);
        total++;
        if (exp_disp === lit) passed++;
        else $display("FAIL %s model got=%h exp=%h", name, exp_disp, lit);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_lit("reset", {SB, S0, S0, S0});
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // A = 012, then B entry starts at 000
        hold(4'b0000, 10);
        hold(4'b0001, 10);
        check_lit("a_01", {SB, S0, S0, S1});
        hold(4'b0011, 10);
        check_lit("b_start", {SB, S0, S0, S0});

        // B = 345 -> sum 0357
        hold(4'b0010, 10);
        hold(4'b0110, 10);
        hold(4'b0111, 10);
        check_lit("sum_0357", {S0, S3, S5, S7});

        // restart A from the sum view
        hold(4'b0100, 10);
        check_lit("a_007", {SB, S0, S0, S7});
        hold(4'b0101, 10);
        check_lit("a_076", {SB, S0, S7, S6});

        // invalid code and a short glitch change nothing
        hold(4'b1111, 10);
        hold(4'b0001, 2);
        hold(4'b1111, 10);
        check_lit("glitch_076", {SB, S0, S7, S6});

        // reset mid-entry discards the partial operand
        do_reset();

        // A = 989, B = 898 -> 1887 exercises every carry
        hold(4'b1101, 10);
        hold(4'b1100, 10);
        hold(4'b1101, 10);
        hold(4'b1100, 10);
        hold(4'b1101, 10);
        hold(4'b1100, 10);
        check_lit("sum_1887", {S1, S8, S8, S7});

        // same digit after only an invalid code is not re-accepted
        hold(4'b1111, 10);
        hold(4'b1100, 10);
        check_lit("repeat_blocked", {S1, S8, S8, S7});

        hold(4'b0110, 10);
        check_lit("a_004", {SB, S0, S0, S4});

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
